// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - RV32I opcodes, type-bit indices and decoded-beat struct
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam int T_R      = 8;
  localparam int T_IALU   = 7;
  localparam int T_LOAD   = 6;
  localparam int T_STORE  = 5;
  localparam int T_BRANCH = 4;
  localparam int T_JAL    = 3;
  localparam int T_LUI    = 2;
  localparam int T_AUIPC  = 1;
  localparam int T_JALR   = 0;

  typedef struct packed {
    logic alusrc;
    logic memtoreg;
    logic mem_we;
    logic reg_en;
    logic pcsrc;
  } ctrl_t;

  // imm is kept at 32 bits; the stage sign-extends it to XLEN on output
  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [8:0]  typ;
    ctrl_t       ctl;
    logic        illegal;
    logic [39:0] chr;
  } decoded_t;

endpackage

// File: rtl/riscv_decode_comb.sv
// rtl/riscv_decode_comb.sv - combinational RV32I instruction decoder
module riscv_decode_comb
  import riscv_pkg::*;
(
  input  logic [31:0] instr,
  output decoded_t    dec
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        legal;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j  = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_u  = {instr[31:12], 12'h000};

  always_comb begin
    dec     = '0;
    dec.rs1 = instr[19:15];
    dec.rs2 = instr[24:20];
    dec.rd  = instr[11:7];
    legal   = 1'b1;
    case (opcode)
      OP_R: begin
        dec.typ[T_R]   = 1'b1;
        dec.ctl.reg_en = 1'b1;
        legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        case (f3)
          3'd0:    dec.chr = f7[5] ? "SUB  " : "ADD  ";
          3'd1:    dec.chr = "SLL  ";
          3'd2:    dec.chr = "SLT  ";
          3'd3:    dec.chr = "SLTU ";
          3'd4:    dec.chr = "XOR  ";
          3'd5:    dec.chr = f7[5] ? "SRA  " : "SRL  ";
          3'd6:    dec.chr = "OR   ";
          default: dec.chr = "AND  ";
        endcase
      end
      OP_IMM: begin
        dec.typ[T_IALU] = 1'b1;
        dec.ctl.alusrc  = 1'b1;
        dec.ctl.reg_en  = 1'b1;
        dec.imm         = imm_i;
        case (f3)
          3'd0: dec.chr = "ADDI ";
          3'd1: begin dec.chr = "SLLI "; legal = (f7 == 7'h00); end
          3'd2: dec.chr = "SLTI ";
          3'd3: dec.chr = "SLTIU";
          3'd4: dec.chr = "XORI ";
          3'd5: begin
            dec.chr = f7[5] ? "SRAI " : "SRLI ";
            legal   = (f7 == 7'h00) || (f7 == 7'h20);
          end
          3'd6:    dec.chr = "ORI  ";
          default: dec.chr = "ANDI ";
        endcase
      end
      OP_LOAD: begin
        dec.typ[T_LOAD]  = 1'b1;
        dec.ctl.alusrc   = 1'b1;
        dec.ctl.memtoreg = 1'b1;
        dec.ctl.reg_en   = 1'b1;
        dec.imm          = imm_i;
        case (f3)
          3'd0:    dec.chr = "LB   ";
          3'd1:    dec.chr = "LH   ";
          3'd2:    dec.chr = "LW   ";
          3'd4:    dec.chr = "LBU  ";
          3'd5:    dec.chr = "LHU  ";
          default: legal = 1'b0;
        endcase
      end
      OP_STORE: begin
        dec.typ[T_STORE] = 1'b1;
        dec.ctl.alusrc   = 1'b1;
        dec.ctl.mem_we   = 1'b1;
        dec.imm          = imm_s;
        case (f3)
          3'd0:    dec.chr = "SB   ";
          3'd1:    dec.chr = "SH   ";
          3'd2:    dec.chr = "SW   ";
          default: legal = 1'b0;
        endcase
      end
      OP_BRANCH: begin
        dec.typ[T_BRANCH] = 1'b1;
        dec.imm           = imm_b;
        case (f3)
          3'd0:    dec.chr = "BEQ  ";
          3'd1:    dec.chr = "BNE  ";
          3'd4:    dec.chr = "BLT  ";
          3'd5:    dec.chr = "BGE  ";
          3'd6:    dec.chr = "BLTU ";
          3'd7:    dec.chr = "BGEU ";
          default: legal = 1'b0;
        endcase
      end
      OP_JAL: begin
        dec.typ[T_JAL] = 1'b1;
        dec.ctl.reg_en = 1'b1;
        dec.ctl.pcsrc  = 1'b1;
        dec.imm        = imm_j;
        dec.chr        = "JAL  ";
      end
      OP_JALR: begin
        dec.typ[T_JALR] = 1'b1;
        dec.ctl.alusrc  = 1'b1;
        dec.ctl.reg_en  = 1'b1;
        dec.ctl.pcsrc   = 1'b1;
        dec.imm         = imm_i;
        dec.chr         = "JALR ";
        legal           = (f3 == 3'd0);
      end
      OP_LUI: begin
        dec.typ[T_LUI] = 1'b1;
        dec.ctl.reg_en = 1'b1;
        dec.imm        = imm_u;
        dec.chr        = "LUI  ";
      end
      OP_AUIPC: begin
        dec.typ[T_AUIPC] = 1'b1;
        dec.ctl.reg_en   = 1'b1;
        dec.imm          = imm_u;
        dec.chr          = "AUIPC";
      end
      default: legal = 1'b0;
    endcase

    // All-zero word is a NOP; bad low bits never match an opcode above
    if (instr == 32'h0) begin
      dec.typ     = '0;
      dec.ctl     = '0;
      dec.imm     = '0;
      dec.illegal = 1'b0;
      dec.chr     = "NOP  ";
    end else if (!legal) begin
      dec.typ     = '0;
      dec.ctl     = '0;
      dec.imm     = '0;
      dec.illegal = 1'b1;
      dec.chr     = "ILLEG";
    end
  end

endmodule

// File: rtl/riscv_decode_stage.sv
// rtl/riscv_decode_stage.sv - registered decode stage with 2-entry skid buffer
module riscv_decode_stage
  import riscv_pkg::*;
#(
  parameter int XLEN             = 32,
  parameter bit EN_MNEMONIC      = 1'b1,
  parameter bit RD_ZERO_SUPPRESS = 1'b1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic [8:0]      out_type,
  output logic            out_alusrc,
  output logic            out_memtoreg,
  output logic            out_mem_we,
  output logic            out_reg_en,
  output logic            out_pcsrc,
  output logic            out_illegal,
  output logic [39:0]     out_char
);

  typedef struct packed {
    decoded_t        dec;
    logic [XLEN-1:0] pc;
  } beat_t;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  decoded_t dec_raw;
  beat_t    in_beat, main_q, skid_q;
  state_t   state_q, state_d;
  logic     ready_q, acc, pop;
  logic     load_main_in, load_main_skid, load_skid_in;

  riscv_decode_comb u_decode (
    .instr (in_instr),
    .dec   (dec_raw)
  );

  always_comb begin
    in_beat.dec = dec_raw;
    in_beat.pc  = in_pc;
    if (RD_ZERO_SUPPRESS && dec_raw.rd == 5'd0) in_beat.dec.ctl.reg_en = 1'b0;
    if (!EN_MNEMONIC) in_beat.dec.chr = '0;
  end

  assign in_ready  = ready_q;
  assign out_valid = (state_q != S_EMPTY);
  assign acc       = in_valid && ready_q;
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_in   = 1'b0;
    case (state_q)
      S_EMPTY: if (acc) begin
        state_d      = S_ONE;
        load_main_in = 1'b1;
      end
      S_ONE: begin
        if (acc && pop) begin
          load_main_in = 1'b1;
        end else if (acc) begin
          state_d      = S_TWO;
          load_skid_in = 1'b1;
        end else if (pop) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: if (pop) begin
        state_d        = S_ONE;
        load_main_skid = 1'b1;
      end
      default: state_d = S_EMPTY;
    endcase
    if (flush) begin
      state_d        = S_EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid_in   = 1'b0;
    end
  end

  // ready is registered from the next state so it never depends on in_valid
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_EMPTY;
      ready_q <= 1'b0;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != S_TWO);
      if (load_main_in)        main_q <= in_beat;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid_in)        skid_q <= in_beat;
    end
  end

  assign out_pc       = main_q.pc;
  assign out_rs1      = main_q.dec.rs1;
  assign out_rs2      = main_q.dec.rs2;
  assign out_rd       = main_q.dec.rd;
  assign out_imm      = XLEN'($signed(main_q.dec.imm));
  assign out_type     = main_q.dec.typ;
  assign out_alusrc   = main_q.dec.ctl.alusrc;
  assign out_memtoreg = main_q.dec.ctl.memtoreg;
  assign out_mem_we   = main_q.dec.ctl.mem_we;
  assign out_reg_en   = main_q.dec.ctl.reg_en;
  assign out_pcsrc    = main_q.dec.ctl.pcsrc;
  assign out_illegal  = main_q.dec.illegal;
  assign out_char     = main_q.dec.chr;

endmodule

// File: tb/tb_riscv_decode_stage.sv
// tb/tb_riscv_decode_stage.sv - self-checking bench for riscv_decode_stage
module tb_riscv_decode_stage;

  localparam int XLEN = 32;
  localparam bit RDZ  = 1'b1;

  logic            clock = 1'b0;
  logic            reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc, out_pc, out_imm;
  logic [4:0]      out_rs1, out_rs2, out_rd;
  logic [8:0]      out_type;
  logic            out_alusrc, out_memtoreg, out_mem_we, out_reg_en, out_pcsrc, out_illegal;
  logic [39:0]     out_char;

  always #5 clock = ~clock;

  riscv_decode_stage #(.XLEN(XLEN), .EN_MNEMONIC(1'b1), .RD_ZERO_SUPPRESS(RDZ)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
    .out_type(out_type), .out_alusrc(out_alusrc), .out_memtoreg(out_memtoreg),
    .out_mem_we(out_mem_we), .out_reg_en(out_reg_en), .out_pcsrc(out_pcsrc),
    .out_illegal(out_illegal), .out_char(out_char)
  );

  typedef struct {
    string      name;
    logic [6:0] op;
    int         f3;
    int         f7;
    int         cls;
    byte        fmt;
  } ent_t;

  typedef struct {
    logic [8:0]  typ;
    logic [4:0]  ctl;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic        ill;
    logic [39:0] chr;
    logic [31:0] pc;
  } exp_t;

  ent_t tbl[$];
  exp_t sb[$];
  int   n_cmp = 0, n_fail = 0, n_pop = 0;
  bit   last_acc;

  function automatic void add(string n, logic [6:0] op, int f3, int f7, int cls, byte fmt);
    ent_t e;
    e.name = n; e.op = op; e.f3 = f3; e.f7 = f7; e.cls = cls; e.fmt = fmt;
    tbl.push_back(e);
  endfunction

  function automatic logic [39:0] to_chr(string s);
    logic [39:0] r;
    for (int i = 0; i < 5; i++) r[39-8*i -: 8] = (i < s.len()) ? s[i] : 8'h20;
    return r;
  endfunction

  // {alusrc, memtoreg, mem_we, reg_en, pcsrc} for each class bit
  function automatic logic [4:0] ctl_of(int cls);
    case (cls)
      8: return 5'b00010;
      7: return 5'b10010;
      6: return 5'b11010;
      5: return 5'b10100;
      4: return 5'b00000;
      3: return 5'b00011;
      0: return 5'b10011;
      default: return 5'b00010;
    endcase
  endfunction

  function automatic logic [31:0] imm_of(byte fmt, logic [31:0] w);
    int v;
    v = 0;
    case (fmt)
      "I": begin v = int'(w[31:20]); if (v >= 2048) v -= 4096; end
      "S": begin v = int'(w[31:25]) * 32 + int'(w[11:7]); if (v >= 2048) v -= 4096; end
      "B": begin
        v = int'(w[31]) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
        if (v >= 4096) v -= 8192;
      end
      "J": begin
        v = int'(w[31]) * (1 << 20) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
        if (v >= (1 << 20)) v -= (1 << 21);
      end
      "U": return w & 32'hFFFFF000;
      default: v = 0;
    endcase
    return 32'(v);
  endfunction

  function automatic exp_t ref_decode(logic [31:0] w, logic [31:0] pc);
    exp_t e;
    int   hit;
    hit = -1;
    e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7]; e.pc = pc;
    e.typ = '0; e.ctl = '0; e.imm = '0; e.ill = 1'b0;
    foreach (tbl[k])
      if (tbl[k].op == w[6:0] && (tbl[k].f3 < 0 || tbl[k].f3 == int'(w[14:12]))
          && (tbl[k].f7 < 0 || tbl[k].f7 == int'(w[31:25]))) hit = k;
    if (hit >= 0) begin
      e.typ = 9'(1) << tbl[hit].cls;
      e.ctl = ctl_of(tbl[hit].cls);
      if (RDZ && e.rd == 5'd0) e.ctl[1] = 1'b0;
      e.imm = imm_of(tbl[hit].fmt, w);
      e.chr = to_chr(tbl[hit].name);
    end else if (w == 32'h0) begin
      e.chr = to_chr("NOP");
    end else begin
      e.ill = 1'b1;
      e.chr = to_chr("ILLEG");
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    ent_t        e;
    int          k;
    k = $urandom_range(0, 11);
    w = $urandom;
    if (k == 0) return 32'h0;
    if (k <= 2) return w;
    e = tbl[$urandom_range(0, tbl.size() - 1)];
    w[6:0] = e.op;
    if (e.f3 >= 0) w[14:12] = e.f3[2:0];
    if (e.f7 >= 0) w[31:25] = e.f7[6:0];
    if (k == 3) w[1:0] = 2'(w[1:0] ^ 2'($urandom_range(1, 3)));
    return w;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_beat(string tag, exp_t e);
    chk({tag, " type"}, out_type, e.typ);
    chk({tag, " ctl"}, {out_alusrc, out_memtoreg, out_mem_we, out_reg_en, out_pcsrc}, e.ctl);
    chk({tag, " imm"}, out_imm, e.imm);
    chk({tag, " rs1"}, out_rs1, e.rs1);
    chk({tag, " rs2"}, out_rs2, e.rs2);
    chk({tag, " rd"}, out_rd, e.rd);
    chk({tag, " illegal"}, out_illegal, e.ill);
    chk({tag, " char"}, out_char, e.chr);
    chk({tag, " pc"}, out_pc, e.pc);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One clock of the handshake against a queue model of beats in flight
  task automatic step();
    bit m_acc, m_pop;
    chk("in_ready", in_ready, sb.size() < 2);
    chk("out_valid", out_valid, sb.size() > 0);
    m_acc = in_valid && (sb.size() < 2);
    m_pop = out_ready && (sb.size() > 0);
    last_acc = 1'b0;
    if (flush) begin
      sb.delete();
    end else begin
      if (m_pop) begin
        check_beat("pop", sb[0]);
        void'(sb.pop_front());
        n_pop++;
      end
      if (m_acc) begin
        sb.push_back(ref_decode(in_instr, in_pc));
        last_acc = 1'b1;
      end
    end
    tick();
  endtask

  task automatic present(logic [31:0] w, logic [31:0] pc);
    out_ready = 1'b1; flush = 1'b0;
    in_valid = 1'b1; in_instr = w; in_pc = pc;
    step();
    in_valid = 1'b0;
    chk("present valid", out_valid, 1'b1);
  endtask

  int pops_before;

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    add("ADD", 7'h33, 0, 0, 8, "R");     add("SUB", 7'h33, 0, 32, 8, "R");
    add("SLL", 7'h33, 1, 0, 8, "R");     add("SLT", 7'h33, 2, 0, 8, "R");
    add("SLTU", 7'h33, 3, 0, 8, "R");    add("XOR", 7'h33, 4, 0, 8, "R");
    add("SRL", 7'h33, 5, 0, 8, "R");     add("SRA", 7'h33, 5, 32, 8, "R");
    add("OR", 7'h33, 6, 0, 8, "R");      add("AND", 7'h33, 7, 0, 8, "R");
    add("ADDI", 7'h13, 0, -1, 7, "I");   add("SLLI", 7'h13, 1, 0, 7, "I");
    add("SLTI", 7'h13, 2, -1, 7, "I");   add("SLTIU", 7'h13, 3, -1, 7, "I");
    add("XORI", 7'h13, 4, -1, 7, "I");   add("SRLI", 7'h13, 5, 0, 7, "I");
    add("SRAI", 7'h13, 5, 32, 7, "I");   add("ORI", 7'h13, 6, -1, 7, "I");
    add("ANDI", 7'h13, 7, -1, 7, "I");
    add("LB", 7'h03, 0, -1, 6, "I");     add("LH", 7'h03, 1, -1, 6, "I");
    add("LW", 7'h03, 2, -1, 6, "I");     add("LBU", 7'h03, 4, -1, 6, "I");
    add("LHU", 7'h03, 5, -1, 6, "I");
    add("SB", 7'h23, 0, -1, 5, "S");     add("SH", 7'h23, 1, -1, 5, "S");
    add("SW", 7'h23, 2, -1, 5, "S");
    add("BEQ", 7'h63, 0, -1, 4, "B");    add("BNE", 7'h63, 1, -1, 4, "B");
    add("BLT", 7'h63, 4, -1, 4, "B");    add("BGE", 7'h63, 5, -1, 4, "B");
    add("BLTU", 7'h63, 6, -1, 4, "B");   add("BGEU", 7'h63, 7, -1, 4, "B");
    add("JAL", 7'h6F, -1, -1, 3, "J");   add("JALR", 7'h67, 0, -1, 0, "I");
    add("LUI", 7'h37, -1, -1, 2, "U");   add("AUIPC", 7'h17, -1, -1, 1, "U");

    tick(); tick();
    chk("reset in_ready", in_ready, 1'b0);
    chk("reset out_valid", out_valid, 1'b0);
    chk("reset type", out_type, 9'h0);
    chk("reset imm", out_imm, 32'h0);
    chk("reset char", out_char, 40'h0);
    chk("reset pc", out_pc, 32'h0);
    reset = 1'b0;
    tick();
    chk("ready after release", in_ready, 1'b1);

    present(32'hFFF00093, 32'h100);
    chk("addi type", out_type, 9'h080);
    chk("addi imm", out_imm, 32'hFFFFFFFF);
    chk("addi rd", out_rd, 5'd1);
    chk("addi alusrc", out_alusrc, 1'b1);
    chk("addi reg_en", out_reg_en, 1'b1);
    chk("addi char", out_char, "ADDI ");
    chk("addi pc", out_pc, 32'h100);
    step();

    present(32'h402081B3, 32'h104);
    chk("sub type", out_type, 9'h100);
    chk("sub regs", {out_rs1, out_rs2, out_rd}, {5'd1, 5'd2, 5'd3});
    chk("sub reg_en", out_reg_en, 1'b1);
    chk("sub char", out_char, "SUB  ");
    step();

    present(32'h0020A423, 32'h108);
    chk("sw type", out_type, 9'h020);
    chk("sw imm", out_imm, 32'd8);
    chk("sw mem_we", out_mem_we, 1'b1);
    chk("sw reg_en", out_reg_en, 1'b0);
    chk("sw char", out_char, "SW   ");
    step();

    present(32'h008000EF, 32'h10C);
    chk("jal type", out_type, 9'h008);
    chk("jal imm", out_imm, 32'd8);
    chk("jal pcsrc", out_pcsrc, 1'b1);
    chk("jal reg_en", out_reg_en, 1'b1);
    step();

    present(32'h00000000, 32'h110);
    chk("nop type", out_type, 9'h0);
    chk("nop char", out_char, "NOP  ");
    chk("nop illegal", out_illegal, 1'b0);
    step();

    present(32'h0000007F, 32'h114);
    chk("illeg flag", out_illegal, 1'b1);
    chk("illeg char", out_char, "ILLEG");
    chk("illeg ctl", {out_alusrc, out_memtoreg, out_mem_we, out_reg_en, out_pcsrc}, 5'b0);
    step();

    // Backpressure: A and B fill the stage, C waits
    pops_before = n_pop;
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = 32'h00100113; in_pc = 32'h200; step();
    in_instr = 32'h00208193; in_pc = 32'h204; step();
    in_instr = 32'h00318213; in_pc = 32'h208;
    chk("bp ready after B", in_ready, 1'b0);
    step();
    chk("bp hold pc", out_pc, 32'h200);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (last_acc) in_valid = 1'b0;
    end
    chk("bp delivered", n_pop - pops_before, 3);
    chk("bp drained", sb.size(), 0);

    // Flush while full with a beat on the input
    pops_before = n_pop;
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = 32'h00500293; in_pc = 32'h300; step();
    in_instr = 32'h00600313; in_pc = 32'h304; step();
    in_instr = 32'h00700393; in_pc = 32'h308; flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush out_valid", out_valid, 1'b0);
    chk("flush in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    repeat (3) step();
    chk("flush no beats", n_pop - pops_before, 0);

    // Reset mid-stream with both entries full
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = 32'h00900493; in_pc = 32'h400; step();
    in_instr = 32'h00A00513; in_pc = 32'h404; step();
    reset = 1'b1; in_valid = 1'b0;
    tick();
    chk("midrst out_valid", out_valid, 1'b0);
    chk("midrst in_ready", in_ready, 1'b0);
    chk("midrst type", out_type, 9'h0);
    chk("midrst char", out_char, 40'h0);
    chk("midrst pc", out_pc, 32'h0);
    sb.delete();
    reset = 1'b0;
    tick();
    present(32'hFFF00093, 32'h500);
    chk("post-reset pc", out_pc, 32'h500);
    step();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = rand_instr();
      in_pc     = $urandom & 32'hFFFFFFFC;
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      step();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) step();
    chk("final drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
